// File: rtl/gpio_input_conditioner_pkg.sv
// gpio_input_conditioner_pkg
// Shared constants for the GPIO input conditioner: channel counts, the reset
// levels of the clean outputs, and the default debounce length.
// No ports (package).
package gpio_input_conditioner_pkg;

    localparam int   BTN_N                   = 3;
    localparam int   SW_N                    = 10;
    localparam logic BTN_RELEASED            = 1'b1;   // buttons are active-low
    localparam logic SW_RESET                = 1'b0;
    localparam int   DEBOUNCE_CYCLES_DEFAULT = 50000;  // 1 ms at 50 MHz

endpackage : gpio_input_conditioner_pkg

// File: rtl/gpio_input_conditioner_if.sv
// gpio_input_conditioner_if
// Bundles the raw board inputs and the conditioned outputs that feed the GPIO
// block.
//   button_raw[3], switch_raw[10]      : asynchronous board inputs
//   button[3], switch[10]              : debounced levels (raw polarity kept)
//   button_press/release[3]            : 1-cycle clean 1->0 / 0->1 pulses
//   switch_changed[10]                 : 1-cycle pulse on any clean transition
// Modports: master = board/consumer side, slave = conditioner side.
interface gpio_input_conditioner_if;
    import gpio_input_conditioner_pkg::*;

    logic [BTN_N-1:0] button_raw;
    logic [SW_N-1:0]  switch_raw;
    logic [BTN_N-1:0] button;
    logic [SW_N-1:0]  switch;
    logic [BTN_N-1:0] button_press;
    logic [BTN_N-1:0] button_release;
    logic [SW_N-1:0]  switch_changed;

    modport master (
        output button_raw, switch_raw,
        input  button, switch, button_press, button_release, switch_changed
    );

    modport slave (
        input  button_raw, switch_raw,
        output button, switch, button_press, button_release, switch_changed
    );
endinterface : gpio_input_conditioner_if

// File: rtl/gpio_input_conditioner_debounce_cell.sv
// debounce_cell
// One input channel: 2-flop synchronizer, stability counter and clean
// register, plus registered rise/fall pulses that coincide with the cycle the
// clean level updates.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   raw          : asynchronous input
//   clean        : debounced level (RESET_VAL after reset)
//   rise, fall   : 1-cycle pulses on clean 0->1 / 1->0
module debounce_cell #(
    parameter logic RESET_VAL       = 1'b0,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter int   CNT_W           = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall
);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             clean_q, clean_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Next-state: synchronizer shift, stability count, clean update and pulses.
    always_comb begin
        sync1_d = raw;
        sync2_d = sync1_q;
        clean_d = clean_q;
        cnt_d   = {CNT_W{1'b0}};
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync2_q != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync2_q;
                cnt_d   = {CNT_W{1'b0}};
                rise_d  = sync2_q;
                fall_d  = ~sync2_q;
            end else begin
                cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end else begin
            // Any agreement restarts the stability window.
            cnt_d = {CNT_W{1'b0}};
        end
    end

    // State registers; synchronizers reload the clean reset level so no
    // spurious transition is seen right after reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
            clean_q <= RESET_VAL;
            cnt_q   <= {CNT_W{1'b0}};
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign clean = clean_q;
    assign rise  = rise_q;
    assign fall  = fall_q;
endmodule : debounce_cell

// File: rtl/gpio_input_conditioner.sv
// gpio_input_conditioner
// Synchronizes and debounces 3 active-low buttons and 10 slide switches and
// produces clean levels plus press/release/change pulses.
// Ports:
//   clock, reset : system clock, synchronous active-high reset
//   gpio         : gpio_input_conditioner_if.slave (raw in, clean/pulses out)
// Optional feature macro: BUTTON_AUTOREPEAT_EN -- when defined, a held button
// re-pulses button_press REPEAT_DELAY cycles after the press, then every
// REPEAT_PERIOD cycles until released.
module gpio_input_conditioner
    import gpio_input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = 16,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                     clock,
    input  logic                     reset,
    gpio_input_conditioner_if.slave  gpio
);
    logic [BTN_N-1:0] btn_clean_s, btn_rise_s, btn_fall_s;
    logic [SW_N-1:0]  sw_clean_s, sw_rise_s, sw_fall_s;

    for (genvar i = 0; i < BTN_N; i++) begin : g_btn
        debounce_cell #(
            .RESET_VAL       (BTN_RELEASED),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clock (clock),
            .reset (reset),
            .raw   (gpio.button_raw[i]),
            .clean (btn_clean_s[i]),
            .rise  (btn_rise_s[i]),
            .fall  (btn_fall_s[i])
        );
    end

    for (genvar i = 0; i < SW_N; i++) begin : g_sw
        debounce_cell #(
            .RESET_VAL       (SW_RESET),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_cell (
            .clock (clock),
            .reset (reset),
            .raw   (gpio.switch_raw[i]),
            .clean (sw_clean_s[i]),
            .rise  (sw_rise_s[i]),
            .fall  (sw_fall_s[i])
        );
    end

`ifdef BUTTON_AUTOREPEAT_EN
    // Sized from the repeat timing itself so long hold times are not bounded
    // by the debounce counter width.
    localparam int RPT_W = $clog2(REPEAT_DELAY + REPEAT_PERIOD) + 1;
    localparam logic [RPT_W-1:0] RPT_FIRST  = RPT_W'(REPEAT_DELAY - 1);
    localparam logic [RPT_W-1:0] RPT_NEXT   = RPT_W'(REPEAT_DELAY + REPEAT_PERIOD - 1);
    localparam logic [RPT_W-1:0] RPT_RELOAD = RPT_W'(REPEAT_DELAY);

    logic [RPT_W-1:0] rpt_cnt_q [BTN_N];
    logic [RPT_W-1:0] rpt_cnt_d [BTN_N];
    logic [BTN_N-1:0] rpt_pulse_q, rpt_pulse_d;

    // Repeat counters: count cycles since the clean press; after the first
    // repeat the counter loops between RPT_RELOAD and RPT_NEXT.
    always_comb begin
        for (int i = 0; i < BTN_N; i++) begin
            rpt_cnt_d[i]   = {RPT_W{1'b0}};
            rpt_pulse_d[i] = 1'b0;
            if (btn_clean_s[i] == 1'b0) begin
                if (rpt_cnt_q[i] == RPT_NEXT) begin
                    rpt_cnt_d[i]   = RPT_RELOAD;
                    rpt_pulse_d[i] = 1'b1;
                end else begin
                    rpt_cnt_d[i]   = rpt_cnt_q[i] + {{(RPT_W-1){1'b0}}, 1'b1};
                    rpt_pulse_d[i] = (rpt_cnt_q[i] == RPT_FIRST);
                end
            end else begin
                rpt_cnt_d[i]   = {RPT_W{1'b0}};
                rpt_pulse_d[i] = 1'b0;
            end
        end
    end

    // Repeat counter and pulse registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < BTN_N; i++) begin
                rpt_cnt_q[i] <= {RPT_W{1'b0}};
            end
            rpt_pulse_q <= {BTN_N{1'b0}};
        end else begin
            for (int i = 0; i < BTN_N; i++) begin
                rpt_cnt_q[i] <= rpt_cnt_d[i];
            end
            rpt_pulse_q <= rpt_pulse_d;
        end
    end

    assign gpio.button_press = btn_fall_s | rpt_pulse_q;
`else
    assign gpio.button_press = btn_fall_s;
`endif

    assign gpio.button         = btn_clean_s;
    assign gpio.switch         = sw_clean_s;
    assign gpio.button_release = btn_rise_s;
    assign gpio.switch_changed = sw_rise_s | sw_fall_s;
endmodule : gpio_input_conditioner
